// File: rtl/ram_arb_pkg.sv
// Shared port identifiers and read-tag type for the two-port RAM arbiter.
package ram_arb_pkg;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    typedef struct packed {
        logic valid;
        logic owner;
    } rd_tag_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant; the port that did not own the last accepted
// command wins when both request.
module rr_arb2
    import ram_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] gnt
);

    logic r_last_owner;
    logic [1:0] w_gnt;

    // Grant decode: bit 0 is port A, bit 1 is port B.
    always_comb begin
        w_gnt = 2'b00;
        case (req)
            2'b01:   w_gnt = 2'b01;
            2'b10:   w_gnt = 2'b10;
            2'b11: begin
                if (r_last_owner == PORT_A) begin
                    w_gnt = 2'b10;
                end else begin
                    w_gnt = 2'b01;
                end
            end
            default: w_gnt = 2'b00;
        endcase
    end

    // Remember who was served last; reset to B so A wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_owner <= PORT_B;
        end else if (accept) begin
            r_last_owner <= w_gnt[1] ? PORT_B : PORT_A;
        end else begin
            r_last_owner <= r_last_owner;
        end
    end

    assign gnt = w_gnt;

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one registered-read single-port RAM between requesters A and B,
// with round-robin command selection and tagged read-data return.
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  a_req,
    input  logic                  a_we,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_wdata,
    output logic                  a_gnt,
    output logic                  a_rvalid,
    output logic [DATA_WIDTH-1:0] a_rdata,
    input  logic                  b_req,
    input  logic                  b_we,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_wdata,
    output logic                  b_gnt,
    output logic                  b_rvalid,
    output logic [DATA_WIDTH-1:0] b_rdata,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_din,
    input  logic [DATA_WIDTH-1:0] ram_dout,
    output logic [CNT_WIDTH-1:0]  contention_cnt
);

    logic [1:0]            w_gnt;
    logic                  w_accept;
    logic                  w_sel_b;
    logic                  w_sel_we;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic [DATA_WIDTH-1:0] w_sel_wdata;

    logic                  r_ram_we;
    logic [ADDR_WIDTH-1:0] r_ram_addr;
    logic [DATA_WIDTH-1:0] r_ram_din;
    rd_tag_t               r_tag1;
    rd_tag_t               r_tag2;
    logic [DATA_WIDTH-1:0] r_a_rdata;
    logic [DATA_WIDTH-1:0] r_b_rdata;
    logic [CNT_WIDTH-1:0]  r_cnt;

    rr_arb2 u_rr_arb2 (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    ({b_req, a_req}),
        .accept (w_accept),
        .gnt    (w_gnt)
    );

    assign a_gnt    = w_gnt[0];
    assign b_gnt    = w_gnt[1];
    assign w_accept = (a_req & w_gnt[0]) | (b_req & w_gnt[1]);
    assign w_sel_b  = w_gnt[1];

    // Command mux for the granted port.
    always_comb begin
        w_sel_we    = a_we;
        w_sel_addr  = a_addr;
        w_sel_wdata = a_wdata;
        if (w_sel_b) begin
            w_sel_we    = b_we;
            w_sel_addr  = b_addr;
            w_sel_wdata = b_wdata;
        end else begin
            w_sel_we    = a_we;
            w_sel_addr  = a_addr;
            w_sel_wdata = a_wdata;
        end
    end

    // RAM pin register; address and data hold when idle so the RAM sees no glitches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ram_we   <= 1'b0;
            r_ram_addr <= {ADDR_WIDTH{1'b0}};
            r_ram_din  <= {DATA_WIDTH{1'b0}};
        end else if (w_accept) begin
            r_ram_we   <= w_sel_we;
            r_ram_addr <= w_sel_addr;
            r_ram_din  <= w_sel_wdata;
        end else begin
            r_ram_we   <= 1'b0;
            r_ram_addr <= r_ram_addr;
            r_ram_din  <= r_ram_din;
        end
    end

    // Read tags follow the command through the pin stage and the RAM stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tag1 <= '{valid: 1'b0, owner: PORT_B};
            r_tag2 <= '{valid: 1'b0, owner: PORT_B};
        end else begin
            r_tag1 <= '{valid: w_accept & ~w_sel_we, owner: w_sel_b};
            r_tag2 <= r_tag1;
        end
    end

    assign a_rvalid = r_tag2.valid & (r_tag2.owner == PORT_A);
    assign b_rvalid = r_tag2.valid & (r_tag2.owner == PORT_B);

    // Keep the last delivered word so rdata is stable between strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_rdata <= {DATA_WIDTH{1'b0}};
            r_b_rdata <= {DATA_WIDTH{1'b0}};
        end else begin
            r_a_rdata <= a_rvalid ? ram_dout : r_a_rdata;
            r_b_rdata <= b_rvalid ? ram_dout : r_b_rdata;
        end
    end

    // RAM output is only valid the cycle after its capture edge, so strobe cycles pass it straight through.
    assign a_rdata = a_rvalid ? ram_dout : r_a_rdata;
    assign b_rdata = b_rvalid ? ram_dout : r_b_rdata;

    // Saturating count of cycles where both ports request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= {CNT_WIDTH{1'b0}};
        end else if (a_req && b_req && (r_cnt != {CNT_WIDTH{1'b1}})) begin
            r_cnt <= r_cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign ram_we         = r_ram_we;
    assign ram_addr       = r_ram_addr;
    assign ram_din        = r_ram_din;
    assign contention_cnt = r_cnt;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Scoreboard bench for ram_port_arbiter with a behavioural registered-read RAM.
module tb_ram_port_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
    logic [3:0] a_addr = 4'd0, b_addr = 4'd0;
    logic [7:0] a_wdata = 8'd0, b_wdata = 8'd0;
    logic       a_gnt, a_rvalid, b_gnt, b_rvalid;
    logic [7:0] a_rdata, b_rdata;
    logic       ram_we;
    logic [3:0] ram_addr;
    logic [7:0] ram_din;
    logic [7:0] ram_dout = 8'd0;
    logic [7:0] contention_cnt;
    logic [7:0] mem [16];

    typedef struct {
        bit         port;
        logic [7:0] data;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    int   compared = 0;
    int   mismatched = 0;
    int   cyc = 0;

    ram_port_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
        .ram_dout(ram_dout), .contention_cnt(contention_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Single-port RAM: write and registered read on the same edge.
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every rvalid strobe must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            if (a_rvalid && b_rvalid) check("both_rvalid", 32'd1, 32'd0);
            if (a_rvalid || b_rvalid) begin
                if (sb.size() == 0) begin
                    check("unexpected_rvalid", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("rvalid_port", {31'd0, b_rvalid}, {31'd0, e.port});
                    check("rdata", {24'd0, (b_rvalid ? b_rdata : a_rdata)}, {24'd0, e.data});
                    check("rvalid_cycle", cyc, e.cyc);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        a_req = 1'b0;
        b_req = 1'b0;
        repeat (n) tick();
    endtask

    // One uncontended command; reads push their hand-computed return value.
    task automatic cmd(input bit port, input bit we, input logic [3:0] addr,
                       input logic [7:0] wd, input logic [7:0] exp_rd);
        a_req = (port == 1'b0);
        b_req = (port == 1'b1);
        if (port) begin
            b_we = we; b_addr = addr; b_wdata = wd;
        end else begin
            a_we = we; a_addr = addr; a_wdata = wd;
        end
        @(negedge clk);
        check(port ? "b_gnt" : "a_gnt", {31'd0, (port ? b_gnt : a_gnt)}, 32'd1);
        check("other_gnt", {31'd0, (port ? a_gnt : b_gnt)}, 32'd0);
        if (!we) sb.push_back('{port: port, data: exp_rd, cyc: cyc + 2});
        tick();
        a_req = 1'b0;
        b_req = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ram_we", {31'd0, ram_we}, 32'd0);
        check("rst_ram_addr", {28'd0, ram_addr}, 32'd0);
        check("rst_ram_din", {24'd0, ram_din}, 32'd0);
        check("rst_rvalid", {30'd0, a_rvalid, b_rvalid}, 32'd0);
        check("rst_rdata", {16'd0, a_rdata, b_rdata}, 32'd0);
        check("rst_cnt", {24'd0, contention_cnt}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // A writes then reads addr 0; B then reads it too (leaves B as last owner)
        cmd(1'b0, 1'b1, 4'd0, 8'hA5, 8'h00);
        check("pin_we", {31'd0, ram_we}, 32'd1);
        check("pin_addr", {28'd0, ram_addr}, 32'd0);
        check("pin_din", {24'd0, ram_din}, 32'hA5);
        cmd(1'b0, 1'b0, 4'd0, 8'h00, 8'hA5);
        check("pin_we_read", {31'd0, ram_we}, 32'd0);
        cmd(1'b1, 1'b0, 4'd0, 8'h00, 8'hA5);
        idle(4);

        // Six cycles of contention: A,B,A,B,A,B
        a_req = 1'b1; a_we = 1'b1; a_addr = 4'd1; a_wdata = 8'h56;
        b_req = 1'b1; b_we = 1'b1; b_addr = 4'd2; b_wdata = 8'hB4;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("rr_a_gnt", {31'd0, a_gnt}, (i % 2 == 0) ? 32'd1 : 32'd0);
            check("rr_b_gnt", {31'd0, b_gnt}, (i % 2 == 1) ? 32'd1 : 32'd0);
            tick();
        end
        idle(0);
        check("cnt_6", {24'd0, contention_cnt}, 32'd6);
        idle(2);

        // Write then immediately read the same address from the other port
        cmd(1'b0, 1'b1, 4'd3, 8'h3C, 8'h00);
        cmd(1'b1, 1'b0, 4'd3, 8'h00, 8'h3C);
        idle(4);

        // Back-to-back reads A,B,A
        cmd(1'b0, 1'b0, 4'd1, 8'h00, 8'h56);
        cmd(1'b1, 1'b0, 4'd2, 8'h00, 8'hB4);
        cmd(1'b0, 1'b0, 4'd0, 8'h00, 8'hA5);
        idle(4);

        // Saturation: last owner is A, so B wins first and grants alternate
        a_req = 1'b1; a_we = 1'b1; a_addr = 4'd4; a_wdata = 8'h11;
        b_req = 1'b1; b_we = 1'b1; b_addr = 4'd5; b_wdata = 8'h22;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            check("sat_a_gnt", {31'd0, a_gnt}, (i % 2 == 1) ? 32'd1 : 32'd0);
            check("sat_onehot", {31'd0, a_gnt ^ b_gnt}, 32'd1);
            tick();
        end
        idle(0);
        check("cnt_sat", {24'd0, contention_cnt}, 32'hFF);
        idle(3);

        // Reset one cycle after a read grant, with a write sitting on the pins
        cmd(1'b0, 1'b0, 4'd0, 8'h00, 8'hA5);
        cmd(1'b0, 1'b1, 4'd0, 8'h77, 8'h00);
        check("pre_rst_we", {31'd0, ram_we}, 32'd1);
        check("pre_rst_a_rvalid", {31'd0, a_rvalid}, 32'd1);
        rst_n = 1'b0;
        sb.delete();
        #1;
        check("async_rst_we", {31'd0, ram_we}, 32'd0);
        check("async_rst_rvalid", {30'd0, a_rvalid, b_rvalid}, 32'd0);
        check("async_rst_cnt", {24'd0, contention_cnt}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(4);

        // After reset A wins the first tie; the dropped write left addr 0 intact
        a_req = 1'b1; a_we = 1'b0; a_addr = 4'd0;
        b_req = 1'b1; b_we = 1'b0; b_addr = 4'd3;
        @(negedge clk);
        check("post_rst_a_gnt", {31'd0, a_gnt}, 32'd1);
        check("post_rst_b_gnt", {31'd0, b_gnt}, 32'd0);
        sb.push_back('{port: 1'b0, data: 8'hA5, cyc: cyc + 2});
        tick();
        idle(0);
        check("post_rst_cnt", {24'd0, contention_cnt}, 32'd1);
        idle(5);

        check("sb_drained", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
